// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter for four requesters.
// Each owner holds the resource for weight(owner) done beats. It is released
// early if it drops its request, or forcibly if TIMEOUT granted cycles pass
// without a done pulse. All outputs come straight from flops.
module wrr_burst_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] weights,
  input  logic        done,
  output logic [3:0]  grant,
  output logic        grant_valid,
  output logic [1:0]  grant_id,
  output logic        timeout_err
);

  localparam logic [7:0] HCNT_MAX = 8'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  credit_q, credit_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [3:0]  grant_q, grant_d;
  logic        grant_valid_q, grant_valid_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic        timeout_err_q, timeout_err_d;

  logic        found;
  logic [1:0]  winner;
  logic        beat_last;
  logic        req_dropped;
  logic        hold_expired;
  logic        release_now;

  // Rotating priority search: first set request starting at p.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic       f;
    logic [1:0] idx;
    logic [1:0] c;
    f   = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      c = p + i[1:0];
      if (!f && r[c]) begin
        f   = 1'b1;
        idx = c;
      end
    end
    return {f, idx};
  endfunction

  // Burst length for a requester; a zero weight still grants one beat.
  function automatic logic [3:0] weight_of(input logic [15:0] w, input logic [1:0] idx);
    logic [3:0] v;
    v = w[4*idx +: 4];
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    hcnt_d        = hcnt_q;
    timeout_err_d = 1'b0;
    found         = 1'b0;
    winner        = '0;
    beat_last     = done && (credit_q == 4'd1);
    req_dropped   = !req[owner_q];
    hold_expired  = !done && (hcnt_q == HCNT_MAX);
    release_now   = 1'b0;

    case (state_q)
      IDLE: begin
        {found, winner} = pick(req, ptr_q);
        if (found) begin
          state_d  = GRANT;
          owner_d  = winner;
          credit_d = weight_of(weights, winner);
          hcnt_d   = '0;
        end
      end
      GRANT: begin
        release_now = beat_last || req_dropped || hold_expired;
        if (release_now) begin
          // Re-arbitrate from the slot after the owner, so the old owner
          // competes at lowest priority and there is no idle bubble.
          ptr_d = owner_q + 2'd1;
          {found, winner} = pick(req, ptr_d);
          timeout_err_d = hold_expired && !req_dropped;
          if (found) begin
            owner_d  = winner;
            credit_d = weight_of(weights, winner);
            hcnt_d   = '0;
          end else begin
            state_d  = IDLE;
            credit_d = '0;
            hcnt_d   = '0;
          end
        end else if (done) begin
          credit_d = credit_q - 4'd1;
          hcnt_d   = '0;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    grant_valid_d = (state_d == GRANT);
    grant_d       = grant_valid_d ? (4'b0001 << owner_d) : 4'b0000;
    grant_id_d    = grant_valid_d ? owner_d : 2'd0;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      credit_q      <= '0;
      hcnt_q        <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      credit_q      <= credit_d;
      hcnt_q        <= hcnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule
